// File: rtl/draw_sequencer_if.sv
// Request/draw bus between the game-flow FSM, draw sequencer and VGA path.
// master = requester side, slave = draw_sequencer.
interface draw_sequencer_if;
  logic        start;
  logic        kind;
  logic        clear;
  logic [3:0]  pos_sel;
  logic [4:0]  mem_sel;
  logic        busy;
  logic        done;
  logic [3:0]  xInitSel;
  logic [1:0]  yInitSel;
  logic        xInitLoad;
  logic        yInitLoad;
  logic [4:0]  memorySel;
  logic        black;
  logic [14:0] rom_addr;
  logic [7:0]  x_off;
  logic [6:0]  y_off;
  logic        plot;

  modport master (
    output start, kind, clear, pos_sel, mem_sel,
    input  busy, done, xInitSel, yInitSel,
    input  xInitLoad, yInitLoad, memorySel, black,
    input  rom_addr, x_off, y_off, plot
  );

  modport slave (
    input  start, kind, clear, pos_sel, mem_sel,
    output busy, done, xInitSel, yInitSel,
    output xInitLoad, yInitLoad, memorySel, black,
    output rom_addr, x_off, y_off, plot
  );
endinterface

// File: rtl/draw_sequencer.sv
// Sequences one sprite or full-screen draw: init-register load, raster
// sweep of ROM addresses, and a plot strobe one cycle behind each address.
module draw_sequencer #(
  parameter int SPRITE_W = 40,
  parameter int SPRITE_H = 40,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic             clk,
  input  logic             reset,
  draw_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAW,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [7:0]  SP_W_M1 = 8'(SPRITE_W - 1);
  localparam logic [6:0]  SP_H_M1 = 7'(SPRITE_H - 1);
  localparam logic [7:0]  SC_W_M1 = 8'(SCREEN_W - 1);
  localparam logic [6:0]  SC_H_M1 = 7'(SCREEN_H - 1);
  localparam logic [14:0] SP_W    = 15'(SPRITE_W);
  localparam logic [14:0] SC_W    = 15'(SCREEN_W);

  state_t      state_q, state_d;
  logic        kind_q, kind_d;
  logic        clear_q, clear_d;
  logic [3:0]  pos_q, pos_d;
  logic [4:0]  mem_q, mem_d;
  logic [7:0]  x_cnt_q, x_cnt_d;
  logic [6:0]  y_cnt_q, y_cnt_d;
  logic [14:0] row_base_q, row_base_d;
  logic [14:0] addr_q, addr_d;
  logic        plot_q, plot_d;
  logic [7:0]  x_off_q, x_off_d;
  logic [6:0]  y_off_q, y_off_d;

  logic [7:0]  w_m1;
  logic [6:0]  h_m1;
  logic [14:0] w_step;
  logic [14:0] addr_now;
  logic        drawing;

  assign w_m1     = kind_q ? SC_W_M1 : SP_W_M1;
  assign h_m1     = kind_q ? SC_H_M1 : SP_H_M1;
  assign w_step   = kind_q ? SC_W : SP_W;
  // row_base tracks y_cnt*W incrementally, so no multiplier is needed
  assign addr_now = row_base_q + 15'(x_cnt_q);
  assign drawing  = (state_q == S_DRAW);

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    clear_d    = clear_q;
    pos_d      = pos_q;
    mem_d      = mem_q;
    x_cnt_d    = x_cnt_q;
    y_cnt_d    = y_cnt_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          kind_d  = bus.kind;
          clear_d = bus.clear;
          pos_d   = bus.pos_sel;
          mem_d   = bus.mem_sel;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        x_cnt_d    = '0;
        y_cnt_d    = '0;
        row_base_d = '0;
        state_d    = S_DRAW;
      end
      S_DRAW: begin
        addr_d = addr_now;
        if (x_cnt_q == w_m1) begin
          x_cnt_d = '0;
          if (y_cnt_q == h_m1) begin
            y_cnt_d    = '0;
            row_base_d = '0;
            state_d    = S_FLUSH;
          end else begin
            y_cnt_d    = y_cnt_q + 7'd1;
            row_base_d = row_base_q + w_step;
          end
        end else begin
          x_cnt_d = x_cnt_q + 8'd1;
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ROM latency is one cycle: plot and offsets trail the address by one
  always_comb begin
    plot_d  = drawing;
    x_off_d = drawing ? x_cnt_q : x_off_q;
    y_off_d = drawing ? y_cnt_q : y_off_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      kind_q     <= 1'b0;
      clear_q    <= 1'b0;
      pos_q      <= '0;
      mem_q      <= '0;
      x_cnt_q    <= '0;
      y_cnt_q    <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      plot_q     <= 1'b0;
      x_off_q    <= '0;
      y_off_q    <= '0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      clear_q    <= clear_d;
      pos_q      <= pos_d;
      mem_q      <= mem_d;
      x_cnt_q    <= x_cnt_d;
      y_cnt_q    <= y_cnt_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      plot_q     <= plot_d;
      x_off_q    <= x_off_d;
      y_off_q    <= y_off_d;
    end
  end

  always_comb begin
    bus.busy      = (state_q != S_IDLE);
    bus.done      = (state_q == S_DONE);
    bus.xInitLoad = (state_q == S_LOAD);
    bus.yInitLoad = (state_q == S_LOAD);
    bus.xInitSel  = '0;
    bus.yInitSel  = '0;
    if (state_q == S_LOAD) begin
      bus.xInitSel = kind_q ? 4'd0 : pos_q;
      bus.yInitSel = kind_q ? 2'b00 : 2'b01;
    end
    bus.memorySel = bus.busy ? mem_q : 5'd0;
    bus.black     = bus.busy & clear_q;
    bus.rom_addr  = drawing ? addr_now : addr_q;
    bus.x_off     = x_off_q;
    bus.y_off     = y_off_q;
    bus.plot      = plot_q;
  end

endmodule

// File: doc/draw_sequencer.md
Name: draw_sequencer

Overview:
- FSM that sequences one full-area draw (a 40x40 sprite, or the 160x120 screen) on the x/y init registers, the colour select mux and the sprite/screen ROMs.
- Latches a request, loads the x/y init registers and sweeps a pixel offset raster.
- Issues synchronous-ROM addresses and emits a plot strobe with matching offsets, one cycle after each address.
- Sits between the game-flow FSM (requester) and the VGA adapter; the VGA coordinate is init + offset.

Parameters:
- SPRITE_W, 40, sprite width in pixels
- SPRITE_H, 40, sprite height in pixels
- SCREEN_W, 160, screen width in pixels
- SCREEN_H, 120, screen height in pixels

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  draw request; sampled only in IDLE
- kind  in  1  0 = sprite, 1 = full screen
- clear  in  1  1 = fill area with black regardless of ROM
- pos_sel  in  4  sprite x-position code (sprites only)
- mem_sel  in  5  colour-mux memory select for this draw
- busy  out  1  high whenever not IDLE
- done  out  1  one-cycle completion pulse
- xInitSel  out  4  to x init register select
- yInitSel  out  2  to y init register select
- xInitLoad  out  1  x init register load enable
- yInitLoad  out  1  y init register load enable
- memorySel  out  5  to colour mux
- black  out  1  to colour mux black override
- rom_addr  out  15  ROM address = y_cnt*W + x_cnt
- x_off  out  8  x offset of plotted pixel
- y_off  out  7  y offset of plotted pixel
- plot  out  1  VGA write strobe

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: on a reset edge, state=IDLE and every output and internal counter is 0. Reset mid-draw aborts immediately; no done pulse; plot=0 from the next cycle.
- Active area per draw: W,H = SPRITE_W,SPRITE_H when kind=0; SCREEN_W,SCREEN_H when kind=1. kind is latched at start.
- States: IDLE -> LOAD -> DRAW -> FLUSH -> DONE -> IDLE.
- IDLE:
  - On start=1, latch kind, clear, pos_sel and mem_sel, then go to LOAD.
  - start in any other state is ignored; there is no queueing.
- LOAD (1 cycle):
  - xInitLoad=yInitLoad=1.
  - xInitSel = kind ? 0 : pos_sel_latched.
  - yInitSel = kind ? 2'b00 : 2'b01.
  - x_cnt=y_cnt=0.
- memorySel and black: equal mem_sel_latched and clear_latched from LOAD through DONE; 0 in IDLE.
- DRAW, one pixel per cycle:
  - rom_addr = y_cnt*W + x_cnt, computed to 15 bits with no truncation.
  - x_cnt increments each cycle. At x_cnt=W-1 it wraps to 0 and y_cnt increments.
  - At x_cnt=W-1 and y_cnt=H-1, go to FLUSH.
- Pipeline (ROM latency 1): plot, x_off and y_off are registered copies of (DRAW active, x_cnt, y_cnt) from the previous cycle. So plot is high for exactly W*H consecutive cycles, starting the cycle after the first DRAW cycle.
- FLUSH (1 cycle): carries the last pixel's plot; rom_addr holds its last value.
- DONE (1 cycle): done=1, plot=0, then go to IDLE.
- busy = (state != IDLE).
- Timing, with start sampled at edge 0:
  - LOAD is cycle 1.
  - DRAW is cycles 2..1+W*H.
  - FLUSH is cycle 2+W*H.
  - DONE is cycle 3+W*H.
  - Sprite: done at cycle 1603. Screen: done at cycle 19203.
- clear=1: sequence and timing unchanged; black=1 for the whole operation, so the colour mux outputs 000.
- Outside DRAW/FLUSH: rom_addr, x_off and y_off hold their last values. plot is low except during the W*H plot window.

Test Plan:
- Reset: assert reset for 2 cycles mid-stream -> all outputs 0; state IDLE; busy=0.
- Sprite draw (start, kind=0, pos_sel=4'b0011, mem_sel=5'd10):
  - LOAD cycle: xInitSel=3, yInitSel=01, both loads=1.
  - 1600 plot pulses, memorySel=10 throughout.
  - First plot: x_off=0, y_off=0.
  - Row wrap: rom_addr 39 -> 40 with (x_off,y_off) going (39,0) -> (0,1).
  - Last plot: (39,39); last rom_addr=1599; done at cycle 1603.
- Screen draw (kind=1) -> xInitSel=0, yInitSel=00; 19200 plots; last rom_addr=19199 at (159,119); done at cycle 19203.
- Start pulses during busy, including on the DONE cycle -> ignored; exactly one done; latched pos_sel/mem_sel unchanged by new inputs.
- Reset at pixel 500 of a sprite draw -> next cycle plot=0, busy=0, no done. A following start then draws all 1600 pixels from (0,0).
- clear=1 sprite, then back-to-back start in the first IDLE cycle after done -> black=1 for the entire first draw, black=0 for the second draw; each draw has 1600 plots.
